// File: rtl/wave_analyzer.sv
// Period / high-time / duty / min-max measurement of a 14-bit sample stream, one result per waveform period.
// Result latency 8 clocks from the crossing sample; no backpressure -- a crossing during a busy divide is dropped and flagged.
module wave_analyzer #(
  parameter int unsigned MID        = 8192,
  parameter int unsigned HYST       = 64,
  parameter int unsigned CW         = 24,
  parameter int unsigned MAX_PERIOD = (2**24) - 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic [13:0]   sample,
  output logic          meas_valid,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_count,
  output logic [7:0]    duty_cycle,
  output logic [13:0]   vmax,
  output logic [13:0]   vmin,
  output logic [13:0]   amplitude,
  output logic          timeout,
  output logic          overrun
);

  localparam int unsigned   DW      = CW + 7;
  localparam logic [13:0]   HI_TH   = 14'(MID + HYST);
  localparam logic [13:0]   LO_TH   = 14'(MID - HYST);
  localparam logic [CW-1:0] TMO_CNT = CW'(MAX_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_hi;
  logic            w_hi_nxt;
  logic            w_rise;
  logic            w_tmo;
  logic            w_div_busy;
  logic [CW-1:0]   r_per_cnt;
  logic [CW-1:0]   r_hi_cnt;
  logic [13:0]     r_max;
  logic [13:0]     r_min;
  logic [CW-1:0]   r_snap_per;
  logic [CW-1:0]   r_snap_hi;
  logic [13:0]     r_snap_max;
  logic [13:0]     r_snap_min;
  logic [3:0]      r_phase;
  logic [DW-1:0]   r_rem;
  logic [6:0]      r_quo;
  logic [2:0]      w_bit;
  logic [DW-1:0]   w_div_sh;
  logic [DW-1:0]   w_dividend;

  // Comparator with hysteresis; holds between thresholds and on invalid samples.
  always_comb begin
    w_hi_nxt = r_hi;
    if (sample_valid) begin
      if (sample >= HI_TH) begin
        w_hi_nxt = 1'b1;
      end else if (sample <= LO_TH) begin
        w_hi_nxt = 1'b0;
      end
    end
  end

  assign w_rise     = sample_valid & ~r_hi & w_hi_nxt;
  assign w_tmo      = sample_valid & ~w_rise & (r_per_cnt == TMO_CNT);
  assign w_div_busy = (r_phase != 4'd0) && (r_phase != 4'd8);

  // Phase 1..7 resolves quotient bits 6..0; quotient never exceeds 100.
  assign w_bit      = 3'(4'd7 - r_phase);
  assign w_div_sh   = DW'(r_snap_per) << w_bit;
  assign w_dividend = DW'(r_hi_cnt) * DW'(100);

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = ARM;
        ARM:     if (w_rise) w_state_nxt = MEAS;
        MEAS:    if (w_tmo) w_state_nxt = ARM;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_hi       <= 1'b0;
      r_per_cnt  <= '0;
      r_hi_cnt   <= '0;
      r_max      <= '0;
      r_min      <= '0;
      r_snap_per <= '0;
      r_snap_hi  <= '0;
      r_snap_max <= '0;
      r_snap_min <= '0;
      r_phase    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      meas_valid <= 1'b0;
      period     <= '0;
      high_count <= '0;
      duty_cycle <= '0;
      vmax       <= '0;
      vmin       <= '0;
      amplitude  <= '0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_hi       <= w_hi_nxt;
      meas_valid <= 1'b0;
      if (!enable || r_state == IDLE) begin
        r_per_cnt <= '0;
        r_hi_cnt  <= '0;
        r_max     <= '0;
        r_min     <= '0;
        r_phase   <= '0;
        if (enable) begin
          timeout <= 1'b0;
          overrun <= 1'b0;
        end
      end else begin
        if (w_div_busy) begin
          if (r_rem >= w_div_sh) begin
            r_rem <= r_rem - w_div_sh;
            r_quo <= {r_quo[5:0], 1'b1};
          end else begin
            r_quo <= {r_quo[5:0], 1'b0};
          end
          r_phase <= r_phase + 4'd1;
        end else if (r_phase == 4'd8) begin
          period     <= r_snap_per;
          high_count <= r_snap_hi;
          duty_cycle <= {1'b0, r_quo};
          vmax       <= r_snap_max;
          vmin       <= r_snap_min;
          amplitude  <= r_snap_max - r_snap_min;
          meas_valid <= 1'b1;
          r_phase    <= '0;
        end
        // The crossing sample opens the new period; a snapshot may share the publish edge.
        if (sample_valid) begin
          if (w_rise) begin
            r_per_cnt <= CW'(1);
            r_hi_cnt  <= CW'(1);
            r_max     <= sample;
            r_min     <= sample;
            if (r_state == MEAS) begin
              if (w_div_busy) begin
                overrun <= 1'b1;
              end else begin
                r_snap_per <= r_per_cnt;
                r_snap_hi  <= r_hi_cnt;
                r_snap_max <= r_max;
                r_snap_min <= r_min;
                r_rem      <= w_dividend;
                r_quo      <= '0;
                r_phase    <= 4'd1;
              end
            end
          end else if (w_tmo) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_phase   <= '0;
            timeout   <= 1'b1;
          end else begin
            r_per_cnt <= r_per_cnt + CW'(1);
            if (w_hi_nxt) r_hi_cnt <= r_hi_cnt + CW'(1);
            if (sample > r_max) r_max <= sample;
            if (sample < r_min) r_min <= sample;
          end
        end
      end
    end
  end

endmodule

// File: doc/wave_analyzer.md
# wave_analyzer

Receive-side measurement block for the DAC waveform path: it consumes a stream of 14-bit unsigned samples (ADC capture or DAC loopback) and measures period, high time, duty cycle in percent, and min/max/peak-to-peak amplitude once per waveform period. It sits between the sample source and the AXI register file, so software can check the frequency, duty cycle and amplitude it programmed on the generator side. Crossings are detected against a mid-scale threshold with hysteresis, and duty cycle comes from a small sequential divider.

## Interface
- MID, 8192, threshold centre (unsigned sample code)
- HYST, 64, hysteresis half-width; high threshold = MID+HYST, low threshold = MID-HYST
- CW, 24, width of the period and high-time counters
- MAX_PERIOD, 2^24-1, sample count with no rising crossing that forces a timeout
- sys_clk  in  1  system clock; all logic on the rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- enable  in  1  measurement enable
- sample_valid  in  1  sample qualifier; only samples with valid=1 are counted
- sample  in  14  unsigned offset-binary sample
- meas_valid  out  1  one-clock pulse when a new result is published
- period  out  CW  valid samples between consecutive rising crossings
- high_count  out  CW  valid samples in that period with the comparator high
- duty_cycle  out  8  floor(high_count*100/period), range 0-100
- vmax, vmin  out  14  extremes over the period
- amplitude  out  14  vmax-vmin
- timeout  out  1  sticky flag; cleared by reset or by enable 0->1
- overrun  out  1  sticky flag, result dropped; same clear rules as timeout

## Operation
- Comparator register `hi`:
  - On a valid sample, set to 1 if sample >= MID+HYST.
  - Cleared to 0 if sample <= MID-HYST; otherwise holds.
  - Reset value 0.
- Rising crossing: a valid sample that takes `hi` from 0 to 1.
- States: IDLE, ARM, MEAS.
  - IDLE: enable=0. Counters cleared. Outputs hold the last published values.
  - IDLE -> ARM when enable=1. Clears timeout and overrun.
  - ARM: waits for the first rising crossing. That crossing opens a period (no result) -> MEAS.
  - MEAS:
    - Each valid sample increments the period counter.
    - It increments the high counter if `hi` (post-update) is 1.
    - It updates running max/min.
    - On a rising crossing: snapshot the counters and max/min, then restart them. The crossing sample counts as sample 1 of the new period, and max/min are re-seeded with its value.
  - A snapshot starts the divider.
- Divider:
  - Restoring division of high_count*100 (CW+7 bits) by period.
  - Produces 7 quotient bits, one per clock.
  - Runs in parallel with counting.
- Publish: period, high_count, duty_cycle, vmax, vmin and amplitude register together, with meas_valid=1 for exactly one clock.
- Overrun: a rising crossing while the divider is busy discards the new snapshot, sets overrun, and lets the in-flight result complete. Counters restart normally.
- Timeout: in ARM or MEAS, when the period counter reaches MAX_PERIOD without a crossing, set timeout, abort the divider, clear the counters and go to ARM. No publish.
- enable=0 in any state: IDLE at the next edge. Any in-flight division is aborted with no meas_valid.
- sys_rst_n=0 at any edge, including mid-division:
  - All outputs 0, flags 0, state IDLE.
  - Comparator 0 and divider idle.
- Simultaneous events:
  - Timeout and crossing on the same sample: the crossing wins.
  - enable=0 overrides everything except reset.

## Timing
- Sample path is registered. A crossing sample accepted at edge E0 is snapshotted at E0.
- Divider iterates at E1..E7; results and meas_valid register at E8. Latency is 8 clocks from the accepting edge and is independent of sample_valid gaps.
- Back-to-back crossings need >= 8 clocks between them. A crossing accepted at E1..E7 overruns.
- Throughput: one sample per clock.

## Test plan
- Square wave, MID=8192, HYST=64, repeating 4×16383 then 4×0, valid every clock:
  - First crossing produces no publish.
  - Each later period publishes period=8, high_count=4, duty_cycle=50, vmax=16383, vmin=0, amplitude=16383.
  - meas_valid goes high 8 clocks after each crossing.
- 2×12000 then 6×1000:
  - period=8, high_count=2, duty_cycle=25, amplitude=11000.
- Same 4/4 pattern with sample_valid=1 only on every 3rd clock:
  - Identical period/high_count/duty_cycle values.
- Samples alternating 8142/8242 (inside hysteresis) with MAX_PERIOD set to 100 in the bench:
  - No meas_valid.
  - timeout=1 after 100 valid samples.
  - Block returns to ARM.
- Pattern 1×16383 then 2×0 (period 3, one sample per clock):
  - First result: period=3, high_count=1, duty_cycle=33.
  - Overrun set, with one publish per completed division.
- sys_rst_n low at E3 of a division, then enable=0 mid-division:
  - All outputs are 0 after reset.
  - No meas_valid pulse.
  - enable 0->1 clears the flags and re-arms.
